// File: rtl/xoodyak_pkg.sv
// xoodyak_pkg: shared opmode/state types and datapath widths for the Xoodyak job sequencer
package xoodyak_pkg;
  localparam int BLK_W = 352;
  localparam int TXT_W = 192;
  localparam int KEY_W = 128;
  typedef enum logic [2:0] {OP_IDLE, OP_KEY, OP_NONCE, OP_ASSOC, OP_ENC, OP_DEC, OP_SQZ, OP_RAT} xood_op_e;
  typedef enum logic [3:0] {S_IDLE, S_KEY, S_NONCE, S_AD_WAIT, S_AD_RUN, S_TX_WAIT, S_TX_RUN, S_SQZ, S_ERR} seq_state_e;
  function automatic logic [4:0] opm(input logic c, input xood_op_e op);
    return {c, 1'b0, op};
  endfunction
endpackage

// File: rtl/xoodyak_watchdog.sv
// xoodyak_watchdog: per-op cycle counter that flags an op running TIMEOUT cycles without finishing
module xoodyak_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  assign o_expire = r_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst || i_load) r_cnt <= '0;
    else if (i_en && !o_expire) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/xoodyak_sequencer.sv
// xoodyak_sequencer: job-level controller issuing KEY/NONCE/ASSOC*/CRYPT*/SQUEEZE ops to xoodyak_build
module xoodyak_sequencer
  import xoodyak_pkg::*;
#(
  parameter int MAXBLK = 16,
  parameter int TIMEOUT = 1024,
  localparam int W = $clog2(MAXBLK + 1)
) (
  input  logic             eph1,
  input  logic             reset,
  input  logic             start,
  input  logic             job_dec,
  input  logic [KEY_W-1:0] job_key,
  input  logic [KEY_W-1:0] job_nonce,
  input  logic [W-1:0]     job_ad_n,
  input  logic [W-1:0]     job_txt_n,
  input  logic             abort,
  input  logic             blk_valid,
  input  logic [BLK_W-1:0] blk_data,
  output logic             blk_ready,
  output logic [4:0]       core_opmode,
  output logic [BLK_W-1:0] core_data,
  input  logic             core_finished,
  input  logic [TXT_W-1:0] core_textout,
  output logic             txt_valid,
  output logic [TXT_W-1:0] txt_data,
  output logic             tag_valid,
  output logic [KEY_W-1:0] tag,
  output logic             busy,
  output logic             err
);
  seq_state_e r_state;
  logic [KEY_W-1:0] r_key, r_nonce, r_tag;
  logic r_dec, r_busy, r_err, r_txt_valid, r_tag_valid;
  logic [W-1:0] r_ad_n, r_txt_n, r_ad_cnt, r_txt_cnt;
  logic [4:0] r_opmode;
  logic [BLK_W-1:0] r_data;
  logic [TXT_W-1:0] r_txt;
  logic w_run, w_wait, w_expire, w_has_txt;
  seq_state_e w_to_txt;
  logic [4:0] w_op_txt;
  assign w_run = r_state inside {S_KEY, S_NONCE, S_AD_RUN, S_TX_RUN, S_SQZ};
  assign w_wait = r_state inside {S_AD_WAIT, S_TX_WAIT};
  assign w_has_txt = r_txt_n != '0;
  assign w_to_txt = w_has_txt ? S_TX_WAIT : S_SQZ;
  assign w_op_txt = w_has_txt ? 5'd0 : opm(1'b0, OP_SQZ);
  assign blk_ready = w_wait && blk_valid && !abort && !reset;
  assign core_opmode = r_opmode;
  assign core_data = r_data;
  assign txt_valid = r_txt_valid;
  assign txt_data = r_txt;
  assign tag_valid = r_tag_valid;
  assign tag = r_tag;
  assign busy = r_busy;
  assign err = r_err;
  // every finish either issues a new op or leaves the run states, so it restarts the count
  xoodyak_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(eph1), .rst(reset), .i_load(!w_run || core_finished), .i_en(w_run), .o_expire(w_expire)
  );
  always_ff @(posedge eph1) begin
    r_txt_valid <= 1'b0;
    r_tag_valid <= 1'b0;
    if (reset) begin
      r_state <= S_IDLE;
      r_opmode <= '0;
      r_data <= '0;
      r_busy <= 1'b0;
      r_err <= 1'b0;
      r_txt <= '0;
      r_tag <= '0;
      r_key <= '0;
      r_nonce <= '0;
      r_dec <= 1'b0;
      r_ad_n <= '0;
      r_txt_n <= '0;
      r_ad_cnt <= '0;
      r_txt_cnt <= '0;
    end else if (abort && r_busy) begin
      r_state <= S_IDLE;
      r_opmode <= '0;
      r_data <= '0;
      r_busy <= 1'b0;
    end else if (w_run && w_expire && !core_finished) begin
      r_state <= S_ERR;
      r_opmode <= '0;
      r_data <= '0;
      r_busy <= 1'b0;
      r_err <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_key <= job_key;
          r_nonce <= job_nonce;
          r_dec <= job_dec;
          r_ad_n <= job_ad_n;
          r_txt_n <= job_txt_n;
          r_ad_cnt <= '0;
          r_txt_cnt <= '0;
          r_err <= 1'b0;
          r_busy <= 1'b1;
          r_state <= S_KEY;
          r_opmode <= opm(1'b0, OP_KEY);
          r_data <= {job_key, 224'h0};
        end
        S_KEY: if (core_finished) begin
          r_state <= S_NONCE;
          r_opmode <= opm(1'b0, OP_NONCE);
          r_data <= {r_nonce, 224'h0};
        end
        S_NONCE: if (core_finished) begin
          r_state <= (r_ad_n != '0) ? S_AD_WAIT : w_to_txt;
          r_opmode <= (r_ad_n != '0) ? 5'd0 : w_op_txt;
          r_data <= '0;
        end
        S_AD_WAIT: if (blk_valid) begin
          r_state <= S_AD_RUN;
          r_opmode <= opm(r_ad_cnt != '0, OP_ASSOC);
          r_data <= blk_data;
          r_ad_cnt <= r_ad_cnt + 1'b1;
        end
        S_AD_RUN: if (core_finished) begin
          r_state <= (r_ad_cnt == r_ad_n) ? w_to_txt : S_AD_WAIT;
          r_opmode <= (r_ad_cnt == r_ad_n) ? w_op_txt : 5'd0;
          r_data <= '0;
        end
        S_TX_WAIT: if (blk_valid) begin
          r_state <= S_TX_RUN;
          r_opmode <= opm(r_txt_cnt != '0, r_dec ? OP_DEC : OP_ENC);
          r_data <= blk_data;
          r_txt_cnt <= r_txt_cnt + 1'b1;
        end
        S_TX_RUN: if (core_finished) begin
          r_txt <= core_textout;
          r_txt_valid <= 1'b1;
          r_state <= (r_txt_cnt == r_txt_n) ? S_SQZ : S_TX_WAIT;
          r_opmode <= (r_txt_cnt == r_txt_n) ? opm(1'b0, OP_SQZ) : 5'd0;
          r_data <= '0;
        end
        S_SQZ: if (core_finished) begin
          r_tag <= core_textout[TXT_W-1:TXT_W-KEY_W];
          r_tag_valid <= 1'b1;
          r_state <= S_IDLE;
          r_opmode <= '0;
          r_busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xoodyak_sequencer.sv
// tb_xoodyak_sequencer: directed jobs against a behavioural core that finishes 3 cycles after each new op
module tb_xoodyak_sequencer;
  logic eph1 = 0, reset = 1, start = 0, job_dec = 0, abort = 0;
  logic [127:0] job_key = '0, job_nonce = '0;
  logic [4:0] job_ad_n = '0, job_txt_n = '0;
  logic blk_valid, blk_ready, core_finished = 0, txt_valid, tag_valid, busy, err;
  logic [351:0] blk_data, core_data;
  logic [4:0] core_opmode;
  logic [191:0] core_textout = '0, txt_data;
  logic [127:0] tag;
  logic [191:0] kx;
  int checks = 0, errors = 0;
  logic clr = 1, src_hold = 0, m_hang = 0;
  int src_idx = 0, src_n = 0;
  logic [31:0] src_seed = '0;
  logic [63:0] seq;
  int seq_n, txt_cnt, tag_cnt;
  logic [191:0] txt0;
  logic [127:0] tag_seen;
  logic [4:0] prev_op = '0, m_prev = '0;
  int m_age = 0;
  xoodyak_sequencer #(.MAXBLK(16), .TIMEOUT(16)) dut (
    .eph1(eph1), .reset(reset), .start(start), .job_dec(job_dec), .job_key(job_key),
    .job_nonce(job_nonce), .job_ad_n(job_ad_n), .job_txt_n(job_txt_n), .abort(abort),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready), .core_opmode(core_opmode),
    .core_data(core_data), .core_finished(core_finished), .core_textout(core_textout),
    .txt_valid(txt_valid), .txt_data(txt_data), .tag_valid(tag_valid), .tag(tag), .busy(busy), .err(err)
  );
  always #5 eph1 = ~eph1;
  assign blk_valid = !src_hold && (src_idx < src_n);
  assign blk_data = {11{src_seed + 32'(src_idx)}};
  always @(posedge eph1) src_idx <= clr ? 0 : (blk_valid && blk_ready) ? src_idx + 1 : src_idx;
  always @(posedge eph1) begin
    int na;
    na = (core_opmode[2:0] == 3'd0 || m_hang) ? 0 : (core_opmode != m_prev) ? 1 : m_age + 1;
    m_prev <= core_opmode;
    m_age <= na;
    core_finished <= (na == 3);
    core_textout <= core_data[351:160] ^ kx ^ 192'(core_opmode);
  end
  always @(posedge eph1) begin
    prev_op <= core_opmode;
    if (clr) begin
      seq <= '0;
      seq_n <= 0;
      txt_cnt <= 0;
      tag_cnt <= 0;
    end else begin
      if (core_opmode != prev_op && core_opmode != 5'd0) begin
        seq <= {seq[55:0], 3'b0, core_opmode};
        seq_n <= seq_n + 1;
      end
      if (txt_valid) begin
        txt_cnt <= txt_cnt + 1;
        if (txt_cnt == 0) txt0 <= txt_data;
      end
      if (tag_valid) begin
        tag_cnt <= tag_cnt + 1;
        tag_seen <= tag;
      end
    end
  end
  task automatic chk(input string t, input logic [351:0] obs, input logic [351:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask
  task automatic go(input logic dec, input logic [4:0] adn, input logic [4:0] txn,
                    input logic [127:0] key, input logic [127:0] nonce, input logic [31:0] seed);
    clr = 1;
    src_seed = seed;
    src_n = int'(adn) + int'(txn);
    @(negedge eph1);
    clr = 0;
    job_dec = dec;
    job_ad_n = adn;
    job_txt_n = txn;
    job_key = key;
    job_nonce = nonce;
    start = 1;
    @(negedge eph1);
    start = 0;
  endtask
  task automatic wait_idle(input string t);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge eph1);
      n++;
    end
    @(negedge eph1);
    chk(t, 352'(n < 400), 352'(1));
  endtask
  initial begin
    int n, nz;
    kx = {6{32'h5A5A_C3C3}};
    repeat (3) @(negedge eph1);
    reset = 0;
    clr = 0;
    chk("rst_opmode", 352'(core_opmode), 352'(0));
    chk("rst_data", core_data, 352'(0));
    chk("rst_flags", 352'({blk_ready, busy, err, txt_valid, tag_valid}), 352'(0));
    go(0, 2, 2, 128'h1111, 128'hA1, 32'h1000_0000);
    wait_idle("t1_done");
    chk("t1_seq", 352'(seq), 352'(64'h0001_0203_1304_1406));
    chk("t1_txt_cnt", 352'(txt_cnt), 352'(2));
    chk("t1_tag_cnt", 352'(tag_cnt), 352'(1));
    chk("t1_txt0", 352'(txt0), 352'({6{32'h1000_0002}} ^ kx ^ 192'h04));
    chk("t1_last_txt", 352'(txt_data), 352'({6{32'h1000_0003}} ^ kx ^ 192'h14));
    chk("t1_tag", 352'(tag_seen), 352'(kx[191:64]));
    chk("t1_idle", 352'({busy, err, core_opmode}), 352'(0));
    go(1, 0, 1, 128'h2222, 128'hB2, 32'h2000_0000);
    wait_idle("t2_done");
    chk("t2_seq", 352'(seq), 352'(64'h0102_0506));
    chk("t2_txt", 352'(txt0), 352'({6{32'h2000_0000}} ^ kx ^ 192'h05));
    chk("t2_err", 352'(err), 352'(0));
    go(0, 2, 0, 128'h3333, 128'hC3, 32'h3000_0000);
    n = 0;
    while (seq_n < 3 && n < 100) begin @(negedge eph1); n++; end
    src_hold = 1;
    while (!core_finished && n < 100) begin @(negedge eph1); n++; end
    chk("t3_reach", 352'(n < 100), 352'(1));
    nz = 0;
    repeat (10) begin
      @(negedge eph1);
      if (core_opmode != 5'd0 || blk_ready) nz++;
    end
    chk("t3_hold_idle", 352'(nz), 352'(0));
    src_hold = 0;
    wait_idle("t3_done");
    chk("t3_seq", 352'(seq), 352'(64'h01_0203_1306));
    chk("t3_tag_cnt", 352'(tag_cnt), 352'(1));
    m_hang = 1;
    go(0, 0, 0, 128'h4444, 128'hD4, 32'h4000_0000);
    chk("t4_issue", 352'(core_opmode), 352'(5'h01));
    n = 0;
    while (!err && n < 40) begin @(negedge eph1); n++; end
    chk("t4_err_cycle", 352'(n), 352'(16));
    chk("t4_err_state", 352'({err, busy, core_opmode}), 352'(7'b1_0_00000));
    m_hang = 0;
    repeat (3) @(negedge eph1);
    chk("t4_err_sticky", 352'(err), 352'(1));
    go(0, 0, 0, 128'h4545, 128'hD5, 32'h4500_0000);
    chk("t4_err_clr", 352'(err), 352'(0));
    wait_idle("t4_done");
    chk("t4_seq", 352'(seq), 352'(64'h01_0206));
    go(0, 0, 2, 128'h5555, 128'hE5, 32'h5000_0000);
    n = 0;
    while (!(seq_n == 4 && core_finished) && n < 100) begin @(negedge eph1); n++; end
    chk("t5_reach", 352'(n < 100), 352'(1));
    abort = 1;
    @(negedge eph1);
    abort = 0;
    chk("t5_abort_idle", 352'({busy, blk_ready, core_opmode}), 352'(0));
    repeat (3) @(negedge eph1);
    chk("t5_txt_cnt", 352'(txt_cnt), 352'(1));
    chk("t5_tag_cnt", 352'(tag_cnt), 352'(0));
    go(0, 1, 1, 128'h5656, 128'hE6, 32'h6000_0000);
    wait_idle("t5b_done");
    chk("t5b_seq", 352'(seq), 352'(64'h01_0203_0406));
    chk("t5b_txt", 352'(txt0), 352'({6{32'h6000_0001}} ^ kx ^ 192'h04));
    chk("t5b_tag_cnt", 352'(tag_cnt), 352'(1));
    go(0, 1, 1, 128'h7777, 128'hF7, 32'h7000_0000);
    job_key = 128'h9999;
    job_nonce = 128'h99;
    job_ad_n = 5'd0;
    start = 1;
    @(negedge eph1);
    start = 0;
    n = 0;
    while (seq_n < 2 && n < 100) begin @(negedge eph1); n++; end
    chk("t6_nonce_data", core_data, {128'hF7, 224'h0});
    reset = 1;
    @(negedge eph1);
    reset = 0;
    chk("t6_rst_opmode", 352'(core_opmode), 352'(0));
    chk("t6_rst_data", core_data, 352'(0));
    chk("t6_rst_flags", 352'({blk_ready, busy, err, txt_valid, tag_valid}), 352'(0));
    chk("t6_rst_regs", 352'({tag, txt_data}), 352'(0));
    go(0, 0, 0, 128'h8888, 128'h88, 32'h8000_0000);
    wait_idle("t6_done");
    chk("t6_seq", 352'(seq), 352'(64'h01_0206));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
